ram_port_arb: RTL and testbench

RAM_PORT_ARB -- requirements
Module: ram_port_arb

---
 rtl/ram_port_arb.sv | 165 ++++++++++++++++
 tb/tb_ram_port_arb.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/ram_port_arb.sv
// Two-port (CPU / debug) arbiter in front of a single-port synchronous data RAM.
// Define RAM_ARB_RR_EN for round-robin arbitration; default is fixed CPU priority.
module ram_port_arb #(
  parameter int RD_LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [9:0]  cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        cpu_ready,
  input  logic        dbg_req,
  input  logic        dbg_we,
  input  logic [9:0]  dbg_addr,
  input  logic [31:0] dbg_wdata,
  output logic [31:0] dbg_rdata,
  output logic        dbg_ready,
  output logic [9:0]  ram_addr,
  output logic        ram_we,
  output logic [31:0] ram_din,
  input  logic [31:0] ram_dout,
  output logic        busy,
  output logic        owner
);

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, DONE} state_t;

  localparam logic [1:0] LAST = 2'(RD_LAT - 1);

  state_t      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic        lat_we_q, lat_we_d;
  logic [9:0]  lat_addr_q, lat_addr_d;
  logic [31:0] lat_wdata_q, lat_wdata_d;
  logic        owner_q, owner_d;
  logic [31:0] cpu_rdata_q, cpu_rdata_d;
  logic [31:0] dbg_rdata_q, dbg_rdata_d;
  logic        cpu_ready_q, cpu_ready_d;
  logic        dbg_ready_q, dbg_ready_d;
  logic [9:0]  ram_addr_q, ram_addr_d;
  logic        ram_we_q, ram_we_d;
  logic [31:0] ram_din_q, ram_din_d;
  logic        busy_q, busy_d;
  logic        win_dbg;
  logic        sel_we;
  logic [9:0]  sel_addr;
  logic [31:0] sel_wdata;

  // Winner among the currently asserted requests (only used when one is high).
  always_comb begin
`ifdef RAM_ARB_RR_EN
    win_dbg = (cpu_req && dbg_req) ? ~owner_q : dbg_req;
`else
    win_dbg = ~cpu_req;
`endif
    sel_we    = win_dbg ? dbg_we    : cpu_we;
    sel_addr  = win_dbg ? dbg_addr  : cpu_addr;
    sel_wdata = win_dbg ? dbg_wdata : cpu_wdata;
  end

  // Outputs are computed for the next state and registered, so every port is a flop.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    lat_we_d    = lat_we_q;
    lat_addr_d  = lat_addr_q;
    lat_wdata_d = lat_wdata_q;
    owner_d     = owner_q;
    cpu_rdata_d = cpu_rdata_q;
    dbg_rdata_d = dbg_rdata_q;
    cpu_ready_d = 1'b0;
    dbg_ready_d = 1'b0;
    ram_addr_d  = '0;
    ram_we_d    = 1'b0;
    ram_din_d   = '0;
    unique case (state_q)
      IDLE: begin
        if (cpu_req || dbg_req) begin
          owner_d     = win_dbg;
          lat_we_d    = sel_we;
          lat_addr_d  = sel_addr;
          lat_wdata_d = sel_wdata;
          ram_addr_d  = sel_addr;
          ram_we_d    = sel_we;
          ram_din_d   = sel_we ? sel_wdata : '0;
          state_d     = ACCESS;
        end
      end
      ACCESS: begin
        if (lat_we_q) begin
          cpu_ready_d = ~owner_q;
          dbg_ready_d = owner_q;
          state_d     = DONE;
        end else begin
          cnt_d      = '0;
          ram_addr_d = lat_addr_q;
          state_d    = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == LAST) begin
          // RAM output is valid at the edge closing the final wait cycle.
          if (owner_q) dbg_rdata_d = ram_dout;
          else         cpu_rdata_d = ram_dout;
          cpu_ready_d = ~owner_q;
          dbg_ready_d = owner_q;
          state_d     = DONE;
        end else begin
          cnt_d      = cnt_q + 2'd1;
          ram_addr_d = lat_addr_q;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      lat_we_q    <= 1'b0;
      lat_addr_q  <= '0;
      lat_wdata_q <= '0;
      owner_q     <= 1'b1;
      cpu_rdata_q <= '0;
      dbg_rdata_q <= '0;
      cpu_ready_q <= 1'b0;
      dbg_ready_q <= 1'b0;
      ram_addr_q  <= '0;
      ram_we_q    <= 1'b0;
      ram_din_q   <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      lat_we_q    <= lat_we_d;
      lat_addr_q  <= lat_addr_d;
      lat_wdata_q <= lat_wdata_d;
      owner_q     <= owner_d;
      cpu_rdata_q <= cpu_rdata_d;
      dbg_rdata_q <= dbg_rdata_d;
      cpu_ready_q <= cpu_ready_d;
      dbg_ready_q <= dbg_ready_d;
      ram_addr_q  <= ram_addr_d;
      ram_we_q    <= ram_we_d;
      ram_din_q   <= ram_din_d;
      busy_q      <= busy_d;
    end
  end

  assign cpu_rdata = cpu_rdata_q;
  assign dbg_rdata = dbg_rdata_q;
  assign cpu_ready = cpu_ready_q;
  assign dbg_ready = dbg_ready_q;
  assign ram_addr  = ram_addr_q;
  assign ram_we    = ram_we_q;
  assign ram_din   = ram_din_q;
  assign busy      = busy_q;
  assign owner     = owner_q;

endmodule

// File: tb/tb_ram_port_arb.sv
// Scoreboard bench for ram_port_arb: stimulus pushes expected ready events,
// a negedge monitor pops and checks port, arrival cycle and read data.
module tb_ram_port_arb;
  localparam int RD_LAT = 1;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req, cpu_we, dbg_req, dbg_we;
  logic [9:0]  cpu_addr, dbg_addr;
  logic [31:0] cpu_wdata, dbg_wdata;
  logic [31:0] cpu_rdata, dbg_rdata;
  logic        cpu_ready, dbg_ready;
  logic [9:0]  ram_addr;
  logic        ram_we;
  logic [31:0] ram_din, ram_dout;
  logic        busy, owner;

  ram_port_arb #(.RD_LAT(RD_LAT)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_rdata(dbg_rdata), .dbg_ready(dbg_ready),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_din(ram_din), .ram_dout(ram_dout),
    .busy(busy), .owner(owner)
  );

  always #5 clk = ~clk;

  // Behavioural synchronous RAM with RD_LAT-cycle read pipeline.
  logic [31:0] mem [1024];
  logic [31:0] rpipe [RD_LAT];
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_din;
    rpipe[0] <= mem[ram_addr];
    for (int i = 1; i < RD_LAT; i++) rpipe[i] <= rpipe[i-1];
  end
  assign ram_dout = rpipe[RD_LAT-1];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit          port;
    bit          rd;
    logic [31:0] data;
    int          cyc;
  } exp_t;
  exp_t q[$];

  int npass = 0;
  int ntotal = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    ntotal++;
    if (act === exp) npass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push(input bit port, input bit rd, input logic [31:0] data, input int c);
    exp_t e;
    e.port = port; e.rd = rd; e.data = data; e.cyc = c;
    q.push_back(e);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_cpu_rdata"}, cpu_rdata, 32'h0);
    check({tag, "_dbg_rdata"}, dbg_rdata, 32'h0);
    check({tag, "_readys"},    {30'h0, cpu_ready, dbg_ready}, 32'h0);
    check({tag, "_ram_we"},    {31'h0, ram_we}, 32'h0);
    check({tag, "_ram_addr"},  {22'h0, ram_addr}, 32'h0);
    check({tag, "_ram_din"},   ram_din, 32'h0);
    check({tag, "_busy"},      {31'h0, busy}, 32'h0);
    check({tag, "_owner"},     {31'h0, owner}, 32'h1);
  endtask

  // Monitor: every ready pulse must match the head of the scoreboard.
  always @(negedge clk) begin
    if (cpu_ready && dbg_ready) begin
      ntotal++;
      $display("FAIL both_ready: cpu_ready=1 dbg_ready=1 at cycle %0d, required one-hot", cyc);
    end
    if (cpu_ready || dbg_ready) begin
      if (q.size() == 0) begin
        ntotal++;
        $display("FAIL unexpected_ready: cpu=%0b dbg=%0b at cycle %0d, required none", cpu_ready, dbg_ready, cyc);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("ready_port", {31'h0, dbg_ready}, {31'h0, e.port});
        check("ready_cycle", cyc, e.cyc);
        if (e.rd) check("rdata", e.port ? dbg_rdata : cpu_rdata, e.data);
      end
    end
  end

  initial begin
    int k;
    for (int i = 0; i < 1024; i++) mem[i] = 32'hA000_0000 | i;
    rst = 1'b1;
    cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
    dbg_req = 0; dbg_we = 0; dbg_addr = '0; dbg_wdata = '0;
    tick(3);
    check_reset_vals("reset");
    rst = 1'b0;
    tick(2);

    // CPU write 0x12345678 -> 0x005
    k = cyc;
    cpu_req = 1; cpu_we = 1; cpu_addr = 10'h005; cpu_wdata = 32'h1234_5678;
    push(0, 0, 32'h0, k + 2);
    tick(1);
    check("wr_access_we",   {31'h0, ram_we}, 32'h1);
    check("wr_access_addr", {22'h0, ram_addr}, 32'h005);
    check("wr_access_din",  ram_din, 32'h1234_5678);
    check("wr_access_busy_owner", {30'h0, busy, owner}, 32'h2);
    cpu_req = 0; cpu_addr = 10'h3FF; cpu_wdata = 32'hFFFF_FFFF;
    tick(1);
    check("wr_done_ram_idle", {ram_we, ram_addr, ram_din[20:0]}, 32'h0);
    tick(2);

    // CPU read back 0x005
    k = cyc;
    cpu_req = 1; cpu_we = 0; cpu_addr = 10'h005;
    push(0, 1, 32'h1234_5678, k + 2 + RD_LAT);
    tick(1);
    check("rd_access", {ram_we, ram_din[20:0], ram_addr}, {1'b0, 21'h0, 10'h005});
    cpu_req = 0;
    tick(1);
    check("rd_wait", {ram_we, 21'h0, ram_addr}, {1'b0, 21'h0, 10'h005});
    tick(RD_LAT);
    check("rd_dbg_rdata_untouched", dbg_rdata, 32'h0);
    tick(2);

    // Debug read of 0x010; address and req disturbed right after grant
    k = cyc;
    dbg_req = 1; dbg_we = 0; dbg_addr = 10'h010;
    push(1, 1, 32'hA000_0010, k + 2 + RD_LAT);
    tick(1);
    dbg_req = 0; dbg_we = 1; dbg_addr = 10'h020; dbg_wdata = 32'h5555_AAAA;
    tick(1);
    check("dbg_wait_addr", {22'h0, ram_addr}, 32'h010);
    tick(RD_LAT + 1);
    check("cpu_rdata_hold", cpu_rdata, 32'h1234_5678);
    tick(2);

    // Both requesters held high for four write transactions
    k = cyc;
    cpu_req = 1; cpu_we = 1; cpu_addr = 10'h030; cpu_wdata = 32'hC0C0_C0C0;
    dbg_req = 1; dbg_we = 1; dbg_addr = 10'h031; dbg_wdata = 32'hD0D0_D0D0;
`ifdef RAM_ARB_RR_EN
    push(0, 0, 32'h0, k + 2);
    push(1, 0, 32'h0, k + 5);
    push(0, 0, 32'h0, k + 8);
    push(1, 0, 32'h0, k + 11);
`else
    push(0, 0, 32'h0, k + 2);
    push(0, 0, 32'h0, k + 5);
    push(0, 0, 32'h0, k + 8);
    push(0, 0, 32'h0, k + 11);
`endif
    tick(11);
    cpu_req = 0; dbg_req = 0;
    tick(3);
    check("arb_mem_cpu", mem[10'h030], 32'hC0C0_C0C0);

    // Reset during the ACCESS cycle of a write
    cpu_req = 1; cpu_we = 1; cpu_addr = 10'h007; cpu_wdata = 32'hDEAD_BEEF;
    tick(1);
    check("rst_access_we", {31'h0, ram_we}, 32'h1);
    rst = 1; cpu_req = 0;
    tick(1);
    check_reset_vals("midrst");
    rst = 0;
    tick(5);
    check("midrst_idle", {30'h0, busy, ram_we}, 32'h0);

    check("scoreboard_empty", q.size(), 32'h0);
    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end
endmodule
